alu_cond_stage: RTL and testbench

//  Execute-stage sequencer around the combinational Alu. Accepts one op via a valid/ready handshake and

---
 rtl/alu_cond_stage.sv | 174 +++++++++++++++++
 tb/tb_alu_cond_stage.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cond_stage.sv
// Execute-stage sequencer around an external combinational Alu: accepts an op
// on a valid/ready handshake, drives the Alu from registered operands, captures
// the result and flags, applies an ARM-style condition check against the NZCV
// register, and presents a registered writeback beat downstream.
// Ports: clk_i, rst_n_i (async, active-low); upstream valid_i/ready_o with
// a_i, b_i, opcode_i, cond_i, setflags_i, rd_i; Alu side alu_a_o, alu_b_o,
// alu_opcode_o, alu_result_i, alu_flags_i ({V,C,Z,N}); flag_clear_i;
// downstream valid_o/ready_i with result_o, rd_o, we_o, flags_o.
// Build option: define COND_EXEC_EN to enable conditional execution; when it
// is undefined cond_i is ignored and every op executes.
module alu_cond_stage #(
  parameter int N    = 4,
  parameter int RD_W = 4
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [N-1:0]    a_i,
  input  logic [N-1:0]    b_i,
  input  logic [2:0]      opcode_i,
  input  logic [3:0]      cond_i,
  input  logic            setflags_i,
  input  logic [RD_W-1:0] rd_i,
  output logic [N-1:0]    alu_a_o,
  output logic [N-1:0]    alu_b_o,
  output logic [2:0]      alu_opcode_o,
  input  logic [N-1:0]    alu_result_i,
  input  logic [3:0]      alu_flags_i,
  input  logic            flag_clear_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [N-1:0]    result_o,
  output logic [RD_W-1:0] rd_o,
  output logic            we_o,
  output logic [3:0]      flags_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [N-1:0]    a_q, b_q;
  logic [2:0]      op_q;
  logic            sf_q;
  logic [RD_W-1:0] rd_q;
  logic [N-1:0]    res_q;
  logic [RD_W-1:0] rdo_q;
  logic            we_q;
  logic [3:0]      flags_q;

  logic accept;
  logic leave_exec;
  logic pass;

`ifdef COND_EXEC_EN
  logic [3:0] cond_q;
  logic       fn, fz, fc, fv;

  // Condition is judged on the flags as they stood before this op.
  assign fv = flags_q[3];
  assign fc = flags_q[2];
  assign fz = flags_q[1];
  assign fn = flags_q[0];

  always_comb begin
    pass = 1'b0;
    unique case (cond_q)
      4'h0: pass = fz;
      4'h1: pass = !fz;
      4'h2: pass = fc;
      4'h3: pass = !fc;
      4'h4: pass = fn;
      4'h5: pass = !fn;
      4'h6: pass = fv;
      4'h7: pass = !fv;
      4'h8: pass = fc & !fz;
      4'h9: pass = !fc | fz;
      4'hA: pass = (fn == fv);
      4'hB: pass = (fn != fv);
      4'hC: pass = !fz & (fn == fv);
      4'hD: pass = fz | (fn != fv);
      4'hE: pass = 1'b1;
      4'hF: pass = 1'b0;
      default: pass = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)
      cond_q <= '0;
    else if (accept)
      cond_q <= cond_i;
  end
`else
  logic unused_cond;

  assign unused_cond = ^cond_i;
  assign pass        = 1'b1;
`endif

  assign ready_o    = (state_q == IDLE) & rst_n_i;
  assign valid_o    = (state_q == DONE);
  assign accept     = valid_i & ready_o;
  assign leave_exec = (state_q == EXEC);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = DONE;
      DONE:    if (ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      a_q  <= '0;
      b_q  <= '0;
      op_q <= '0;
      sf_q <= 1'b0;
      rd_q <= '0;
    end else if (accept) begin
      a_q  <= a_i;
      b_q  <= b_i;
      op_q <= opcode_i;
      sf_q <= setflags_i;
      rd_q <= rd_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      res_q <= '0;
      rdo_q <= '0;
      we_q  <= 1'b0;
    end else if (leave_exec) begin
      res_q <= alu_result_i;
      rdo_q <= rd_q;
      we_q  <= pass;
    end
  end

  // A flag update from the executing op outranks a coincident clear.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)
      flags_q <= '0;
    else if (leave_exec & pass & sf_q)
      flags_q <= alu_flags_i;
    else if (flag_clear_i)
      flags_q <= '0;
  end

  assign alu_a_o      = a_q;
  assign alu_b_o      = b_q;
  assign alu_opcode_o = op_q;
  assign result_o     = res_q;
  assign rd_o         = rdo_q;
  assign we_o         = we_q;
  assign flags_o      = flags_q;

endmodule

// File: tb/tb_alu_cond_stage.sv
// Scoreboard bench for alu_cond_stage with a behavioural Alu on its Alu port.
// Expected beats are queued at issue and compared when valid_o rises.
module tb_alu_cond_stage;

  localparam int N    = 4;
  localparam int RD_W = 4;

  logic            clk_i = 1'b0;
  logic            rst_n_i;
  logic            valid_i;
  logic            ready_o;
  logic [N-1:0]    a_i, b_i;
  logic [2:0]      opcode_i;
  logic [3:0]      cond_i;
  logic            setflags_i;
  logic [RD_W-1:0] rd_i;
  logic [N-1:0]    alu_a_o, alu_b_o;
  logic [2:0]      alu_opcode_o;
  logic [N-1:0]    alu_result_i;
  logic [3:0]      alu_flags_i;
  logic            flag_clear_i;
  logic            valid_o;
  logic            ready_i;
  logic [N-1:0]    result_o;
  logic [RD_W-1:0] rd_o;
  logic            we_o;
  logic [3:0]      flags_o;

  typedef struct packed {
    logic [N-1:0]    res;
    logic [RD_W-1:0] rd;
    logic            we;
    logic [3:0]      flags;
  } beat_t;

  beat_t q[$];
  logic [3:0] mflags;
  int n_vec = 0;
  int n_bad = 0;

  always #5 clk_i = ~clk_i;

  alu_cond_stage #(.N(N), .RD_W(RD_W)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .valid_i(valid_i), .ready_o(ready_o),
    .a_i(a_i), .b_i(b_i), .opcode_i(opcode_i),
    .cond_i(cond_i), .setflags_i(setflags_i), .rd_i(rd_i),
    .alu_a_o(alu_a_o), .alu_b_o(alu_b_o),
    .alu_opcode_o(alu_opcode_o),
    .alu_result_i(alu_result_i), .alu_flags_i(alu_flags_i),
    .flag_clear_i(flag_clear_i),
    .valid_o(valid_o), .ready_i(ready_i),
    .result_o(result_o), .rd_o(rd_o), .we_o(we_o),
    .flags_o(flags_o)
  );

  // Returns {flags[3:0], result[N-1:0]}; flags are {V,C,Z,N}.
  function automatic logic [N+3:0] alu(
    input logic [N-1:0] a, input logic [N-1:0] b,
    input logic [2:0] op);
    logic [N:0]   s;
    logic [N-1:0] r;
    logic         c, v;
    s = '0; c = 1'b0; v = 1'b0;
    case (op)
      3'd0: begin
        s = {1'b0, a} + {1'b0, b};
        c = s[N];
        v = (a[N-1] == b[N-1]) && (s[N-1] != a[N-1]);
      end
      3'd1: begin
        s = {1'b0, a} + {1'b0, ~b} + 1'b1;
        c = s[N];
        v = (a[N-1] != b[N-1]) && (s[N-1] != a[N-1]);
      end
      3'd2: s = {1'b0, a & b};
      3'd3: s = {1'b0, a | b};
      default: s = '0;
    endcase
    r = s[N-1:0];
    return {v, c, (r == '0), r[N-1], r};
  endfunction

  always_comb begin
    {alu_flags_i, alu_result_i} = alu(alu_a_o, alu_b_o, alu_opcode_o);
  end

  function automatic logic cond_ok(input logic [3:0] c,
                                   input logic [3:0] f);
    logic v, cy, z, ng;
    {v, cy, z, ng} = f;
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cy;
      4'h3: return !cy;
      4'h4: return ng;
      4'h5: return !ng;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cy && !z;
      4'h9: return !cy || z;
      4'hA: return ng == v;
      4'hB: return ng != v;
      4'hC: return !z && (ng == v);
      4'hD: return z || (ng != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_beat(input string tag, input beat_t e);
    chk({tag, ".res"},   32'(result_o), 32'(e.res));
    chk({tag, ".rd"},    32'(rd_o),     32'(e.rd));
    chk({tag, ".we"},    32'(we_o),     32'(e.we));
    chk({tag, ".flags"}, 32'(flags_o),  32'(e.flags));
  endtask

  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [2:0] op, input logic [3:0] cond,
                        input logic sf, input logic [RD_W-1:0] rd,
                        input logic clr, input int hold);
    beat_t e;
    logic [N+3:0] ar;
    logic p;
    int lat;
    ar = alu(a, b, op);
`ifdef COND_EXEC_EN
    p = cond_ok(cond, mflags);
`else
    p = 1'b1;
`endif
    e.res = ar[N-1:0];
    e.rd  = rd;
    e.we  = p;
    if (p && sf)   mflags = ar[N+3:N];
    else if (clr)  mflags = 4'h0;
    e.flags = mflags;
    q.push_back(e);

    @(negedge clk_i);
    chk("ready_idle", 32'(ready_o), 32'd1);
    valid_i = 1'b1; a_i = a; b_i = b; opcode_i = op;
    cond_i = cond; setflags_i = sf; rd_i = rd;
    ready_i = (hold == 0);
    @(negedge clk_i);
    valid_i = 1'b0;
    flag_clear_i = clr;
    lat = 1;
    while (!valid_o && lat < 6) begin
      @(negedge clk_i);
      flag_clear_i = 1'b0;
      lat++;
    end
    flag_clear_i = 1'b0;
    chk("latency", 32'(lat), 32'd2);
    if (q.size() == 0) begin
      chk("queue_empty", 32'd0, 32'd1);
      return;
    end
    e = q.pop_front();
    chk_beat("beat", e);
    for (int i = 0; i < hold; i++) begin
      valid_i = i[0];
      @(negedge clk_i);
      chk_beat("hold", e);
      chk("hold.ready", 32'(ready_o), 32'd0);
      chk("hold.valid", 32'(valid_o), 32'd1);
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    @(negedge clk_i);
    chk("drain.valid", 32'(valid_o), 32'd0);
  endtask

  initial begin
    rst_n_i = 1'b0; valid_i = 1'b0; a_i = '0; b_i = '0;
    opcode_i = '0; cond_i = '0; setflags_i = 1'b0; rd_i = '0;
    flag_clear_i = 1'b0; ready_i = 1'b1; mflags = 4'h0;
    repeat (2) @(negedge clk_i);
    chk("rst.ready", 32'(ready_o), 32'd0);
    chk("rst.valid", 32'(valid_o), 32'd0);
    rst_n_i = 1'b1;

    // ADD 7+1 AL with S: result 1000, flags V=1 N=1
    run_op(4'd7, 4'd1, 3'd0, 4'hE, 1'b1, 4'd2, 1'b0, 0);
    chk("add.res", 32'(result_o), 32'h8);
    chk("add.flags", 32'(flags_o), 32'h9);

    // Reset in the middle of an op
    @(negedge clk_i);
    valid_i = 1'b1; a_i = 4'd3; b_i = 4'd4; opcode_i = 3'd0;
    cond_i = 4'hE; setflags_i = 1'b1; rd_i = 4'd5;
    @(negedge clk_i);
    valid_i = 1'b0;
    rst_n_i = 1'b0;
    #1;
    chk("mid.ready", 32'(ready_o), 32'd0);
    chk("mid.valid", 32'(valid_o), 32'd0);
    chk("mid.we", 32'(we_o), 32'd0);
    chk("mid.flags", 32'(flags_o), 32'd0);
    chk("mid.res", 32'(result_o), 32'd0);
    mflags = 4'h0;
    @(negedge clk_i);
    rst_n_i = 1'b1;
    @(negedge clk_i);
    chk("post.ready", 32'(ready_o), 32'd1);
    chk("post.valid", 32'(valid_o), 32'd0);

    // SUB 3-3 sets Z; AND under EQ executes; OR under NE skipped
    run_op(4'd3, 4'd3, 3'd1, 4'hE, 1'b1, 4'd1, 1'b0, 0);
    run_op(4'd5, 4'd3, 3'd2, 4'h0, 1'b0, 4'd3, 1'b0, 0);
    chk("and.res", 32'(result_o), 32'h1);
    run_op(4'd5, 4'd8, 3'd3, 4'h1, 1'b1, 4'd4, 1'b0, 0);

    // Back-pressure with ignored valid_i pulses
    run_op(4'd9, 4'd4, 3'd1, 4'hE, 1'b1, 4'd6, 1'b0, 5);

    // Clear coincident with flag update, then clear alone
    run_op(4'd8, 4'd8, 3'd0, 4'hE, 1'b1, 4'd7, 1'b1, 0);
    @(negedge clk_i);
    flag_clear_i = 1'b1;
    @(negedge clk_i);
    flag_clear_i = 1'b0;
    mflags = 4'h0;
    chk("clear.flags", 32'(flags_o), 32'd0);

    // Never condition with S
    run_op(4'd2, 4'd2, 3'd1, 4'hF, 1'b1, 4'd8, 1'b0, 0);

    for (int i = 0; i < 40; i++)
      run_op(4'($urandom_range(15)), 4'($urandom_range(15)),
             3'($urandom_range(3)), 4'($urandom_range(15)),
             1'($urandom_range(1)), 4'($urandom_range(15)),
             1'($urandom_range(1)), (i % 7 == 0) ? 2 : 0);

    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
